// File: rtl/seq_mult_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_param_pkg
// Purpose  : Shared FSM state encodings and the legal STEP set for the
//            sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic bit step_is_legal(input int step);
        return (step == 1) || (step == 2) || (step == 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_param_acc_adder.sv
`default_nettype none
// ============================================================================
// Module   : mult_acc_adder
// Purpose  : Combinational accumulator update, acc +/- addend modulo 2^W.
// Revision : 1.0 - initial release
// ============================================================================
module mult_acc_adder #(
    parameter int W = 17
) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_addend,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_sub ? (i_acc - i_addend) : (i_acc + i_addend);

endmodule
`default_nettype wire

// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_param
// Purpose  : Radix-2^STEP sequential signed/unsigned multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_param
    import seq_mult_param_pkg::*;
#(
    parameter int A_W  = 8,
    parameter int B_W  = 9,
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [A_W-1:0]       in_a,
    input  logic [B_W-1:0]       in_b,
    output logic                 busy,
    output logic                 data_valid,
    output logic [A_W+B_W-1:0]   out
);

    localparam int P_W     = A_W + B_W;
    localparam int ITER    = (A_W + STEP - 1) / STEP;
    localparam int C_EXT_W = ITER * STEP;
    localparam int C_CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(ITER - 1);
    localparam logic [STEP:0]      C_SPAN = {1'b1, {STEP{1'b0}}};

    generate
        if (!step_is_legal(STEP)) begin : g_step_check
            $error("seq_mult_param: STEP must be 1, 2 or 4");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;
    logic [C_EXT_W-1:0]   r_a;
    logic [P_W-1:0]       r_b;
    logic                 r_signed;
    logic [P_W-1:0]       r_acc;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [P_W-1:0]       r_out;
    logic                 r_valid;

    logic [C_EXT_W-1:0]   w_a_ext;
    logic [P_W-1:0]       w_b_ext;
    logic [STEP-1:0]      w_slice;
    logic                 w_neg;
    logic [STEP:0]        w_mag;
    logic [P_W-1:0]       w_mag_ext;
    logic [P_W-1:0]       w_pp;
    logic [P_W-1:0]       w_sum;

    always_comb begin
        w_a_ext = C_EXT_W'(in_a);
        w_b_ext = P_W'(in_b);
        if (signed_mode) begin
            w_a_ext = C_EXT_W'($signed(in_a));
            w_b_ext = P_W'($signed(in_b));
        end
    end

    // Multiplier shifts right and multiplicand shifts left each RUN cycle, so
    // the partial product is always slice x r_b with no variable shifter.
    // A negative top slice is added as the subtraction of its magnitude.
    assign w_slice   = r_a[STEP-1:0];
    assign w_neg     = r_signed && (r_cnt == C_LAST) && w_slice[STEP-1];
    assign w_mag     = w_neg ? (C_SPAN - {1'b0, w_slice}) : {1'b0, w_slice};
    assign w_mag_ext = {{(P_W-STEP-1){1'b0}}, w_mag};
    assign w_pp      = w_mag_ext * r_b;

    mult_acc_adder #(
        .W (P_W)
    ) u_acc_adder (
        .i_acc    (r_acc),
        .i_addend (w_pp),
        .i_sub    (w_neg),
        .o_sum    (w_sum)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == C_LAST) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= w_a_ext;
                        r_b      <= w_b_ext;
                        r_signed <= signed_mode;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_sum;
                    r_a   <= r_a >> STEP;
                    r_b   <= r_b << STEP;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_DONE: begin
                    r_out   <= r_acc;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign data_valid = r_valid;
    assign out        = r_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_param
// Purpose  : Directed self-checking bench for seq_mult_param, STEP = 1/2/4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_param;

    localparam int P_W = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             sm;
    logic [7:0]       a;
    logic [8:0]       b;
    logic [2:0]       start;
    logic [2:0]       busy;
    logic [2:0]       dv;
    logic [P_W-1:0]   out_w [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.A_W(8), .B_W(9), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start[0]), .signed_mode(sm), .in_a(a), .in_b(b),
        .busy(busy[0]), .data_valid(dv[0]), .out(out_w[0]));
    seq_mult_param #(.A_W(8), .B_W(9), .STEP(2)) u_s2 (
        .clk(clk), .rst(rst), .start(start[1]), .signed_mode(sm), .in_a(a), .in_b(b),
        .busy(busy[1]), .data_valid(dv[1]), .out(out_w[1]));
    seq_mult_param #(.A_W(8), .B_W(9), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start[2]), .signed_mode(sm), .in_a(a), .in_b(b),
        .busy(busy[2]), .data_valid(dv[2]), .out(out_w[2]));

    function automatic logic [16:0] ref_mult(input logic [7:0] ia, input logic [8:0] ib, input logic s);
        logic signed [16:0] ps;
        if (s) begin
            ps = 17'($signed(ia)) * 17'($signed(ib));
            return 17'(ps);
        end
        return 17'(ia) * 17'(ib);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one multiply on instance d, scrambles the operand inputs after
    // capture, then checks latency (capture edge counted as 1) and product.
    task automatic do_mult(input int d, input logic [7:0] ia, input logic [8:0] ib,
                           input logic s, input logic [16:0] exp_o, input int exp_lat,
                           input string tag);
        int n;
        check({tag, "/idle"}, 32'(busy[d]), 32'd0);
        a = ia; b = ib; sm = s; start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        a = 8'($urandom); b = 9'($urandom); sm = ~s;
        check({tag, "/busy"}, 32'(busy[d]), 32'd1);
        n = 1;
        while (dv[d] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'(exp_lat));
        check({tag, "/out"}, 32'(out_w[d]), 32'(exp_o));
    endtask

    initial begin
        int n;
        int pulses;
        logic [7:0] ra;
        logic [8:0] rb;
        logic       rs;

        rst = 1'b1; start = 3'b000; sm = 1'b0; a = '0; b = '0;
        #2;
        for (int d = 0; d < 3; d++) begin
            check("rst/busy", 32'(busy[d]), 32'd0);
            check("rst/dv",   32'(dv[d]),   32'd0);
            check("rst/out",  32'(out_w[d]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed STEP=1 vectors, issued back-to-back
        do_mult(0, 8'h80, 9'h100, 1'b1, 17'h08000, 10, "s1_mneg_mneg");
        do_mult(0, 8'h80, 9'h0FF, 1'b1, 17'h18080, 10, "s1_mneg_255");
        do_mult(0, 8'h03, 9'h1FB, 1'b1, 17'h1FFF1, 10, "s1_3_m5");
        do_mult(0, 8'hFF, 9'h1FF, 1'b0, 17'h1FD01, 10, "s1_uns_max");
        do_mult(0, 8'hFF, 9'h1FF, 1'b1, 17'h00001, 10, "s1_m1_m1");

        repeat (3) @(posedge clk);
        #1 check("s1_hold/out", 32'(out_w[0]), 32'h00001);

        // Start pulses while busy must be ignored
        a = 8'h03; b = 9'h1FB; sm = 1'b1; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; a = 8'd100; b = 9'd77; sm = 1'b0;
        n = 1;
        while (dv[0] !== 1'b1 && n < 40) begin
            start[0] = (n == 3 || n == 6);
            @(posedge clk); #1;
            n++;
        end
        start[0] = 1'b0;
        check("ignore/latency", 32'(n), 32'd10);
        check("ignore/out", 32'(out_w[0]), 32'h1FFF1);
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (dv[0] === 1'b1) pulses++;
        end
        check("ignore/extra_dv", 32'(pulses), 32'd0);
        check("ignore/busy", 32'(busy[0]), 32'd0);

        // Asynchronous reset four edges into RUN aborts the operation
        a = 8'h80; b = 9'h0FF; sm = 1'b1; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("abort/busy_pre", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("abort/busy", 32'(busy[0]), 32'd0);
        check("abort/dv",   32'(dv[0]),   32'd0);
        check("abort/out",  32'(out_w[0]), 32'd0);
        #1 rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (dv[0] === 1'b1) pulses++;
        end
        check("abort/no_dv", 32'(pulses), 32'd0);
        do_mult(0, 8'h80, 9'h0FF, 1'b1, 17'h18080, 10, "abort/restart");

        // Wider STEP: directed then random back-to-back
        do_mult(1, 8'h80, 9'h100, 1'b1, 17'h08000, 6, "s2_mneg_mneg");
        do_mult(1, 8'hFF, 9'h1FF, 1'b0, 17'h1FD01, 6, "s2_uns_max");
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 9'($urandom); rs = 1'($urandom_range(0, 1));
            do_mult(1, ra, rb, rs, ref_mult(ra, rb, rs), 6, "s2_rand");
        end
        do_mult(2, 8'h80, 9'h100, 1'b1, 17'h08000, 4, "s4_mneg_mneg");
        do_mult(2, 8'h03, 9'h1FB, 1'b1, 17'h1FFF1, 4, "s4_3_m5");
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 9'($urandom); rs = 1'($urandom_range(0, 1));
            do_mult(2, ra, rb, rs, ref_mult(ra, rb, rs), 4, "s4_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
